// File: rtl/lpc_frame_packer.sv
// Packs NUM_FIELDS quantized LPC fields into one frame word for the 81-bit stream master.
// Optional LPC_PACK_ZERO_FILL_EN: an early PARAM_LAST ends the frame and zero-fills the remaining fields.
module lpc_frame_packer #(
    parameter int unsigned FIELD_W    = 9,
    parameter int unsigned NUM_FIELDS = 9
) (
    input  logic                            ACLK,
    input  logic                            ARESET_N,
    input  logic [FIELD_W-1:0]              PARAM_IN,
    input  logic                            PARAM_VALID,
    output logic                            PARAM_READY,
    input  logic                            PARAM_LAST,
    input  logic                            FLUSH,
    output logic [FIELD_W*NUM_FIELDS-1:0]   SAMPLE,
    output logic                            VALID_SAMPLE,
    input  logic                            READY,
    output logic [3:0]                      LAST
);

    localparam int unsigned FRAME_W = FIELD_W * NUM_FIELDS;
    localparam int unsigned CNT_W   = $clog2(NUM_FIELDS);
    localparam int unsigned IDX_W   = $clog2(FRAME_W);
    localparam int unsigned SEQ_W   = 3;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [FRAME_W-1:0] asm_q, asm_d;
    logic               asm_last_q, asm_last_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [FRAME_W-1:0] sample_q, sample_d;
    logic [3:0]         last_q, last_d;
    logic               valid_q, valid_d;
    logic               rdy_q, rdy_d;

    logic               accept;
    logic               consume;
    logic               frame_end;
    logic [IDX_W-1:0]   field_msb;
    logic [FRAME_W-1:0] asm_ins;
    logic               xfer;
    logic [FRAME_W-1:0] xfer_frame;
    logic               xfer_last;

    assign PARAM_READY  = rdy_q;
    assign SAMPLE       = sample_q;
    assign VALID_SAMPLE = valid_q;
    assign LAST         = last_q;

    // State and datapath registers
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state_q    <= ST_COLLECT;
            fcnt_q     <= '0;
            asm_q      <= '0;
            asm_last_q <= 1'b0;
            seq_q      <= '0;
            sample_q   <= '0;
            last_q     <= '0;
            valid_q    <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            asm_q      <= asm_d;
            asm_last_q <= asm_last_d;
            seq_q      <= seq_d;
            sample_q   <= sample_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            rdy_q      <= rdy_d;
        end
    end

    // Next-state: field assembly, hand-off to the output register, flush
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        asm_d      = asm_q;
        asm_last_d = asm_last_q;
        seq_d      = seq_q;
        sample_d   = sample_q;
        last_d     = last_q;
        valid_d    = valid_q;
        xfer       = 1'b0;
        xfer_frame = '0;
        xfer_last  = 1'b0;

        accept    = PARAM_VALID && rdy_q;
        consume   = READY && valid_q;
        field_msb = IDX_W'(FRAME_W - 1) - IDX_W'(fcnt_q) * IDX_W'(FIELD_W);
        asm_ins   = asm_q;
        asm_ins[field_msb -: FIELD_W] = PARAM_IN;
        frame_end = (fcnt_q == CNT_W'(NUM_FIELDS - 1));
`ifdef LPC_PACK_ZERO_FILL_EN
        frame_end = frame_end || PARAM_LAST;
`endif

        if (consume) begin
            valid_d = 1'b0;
        end

        if (FLUSH) begin
            state_d    = ST_COLLECT;
            fcnt_d     = '0;
            asm_d      = '0;
            asm_last_d = 1'b0;
            seq_d      = '0;
            sample_d   = '0;
            last_d     = '0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        if (frame_end) begin
                            fcnt_d = '0;
                            if (!valid_q || consume) begin
                                xfer       = 1'b1;
                                xfer_frame = asm_ins;
                                xfer_last  = PARAM_LAST;
                                asm_d      = '0;
                            end else begin
                                asm_d      = asm_ins;
                                asm_last_d = PARAM_LAST;
                                state_d    = ST_HOLD;
                            end
                        end else begin
                            asm_d  = asm_ins;
                            fcnt_d = fcnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        xfer       = 1'b1;
                        xfer_frame = asm_q;
                        xfer_last  = asm_last_q;
                        asm_d      = '0;
                        asm_last_d = 1'b0;
                        state_d    = ST_COLLECT;
                    end
                end
                default: state_d = ST_COLLECT;
            endcase
        end

        // Sequence number restarts after an end-of-stream frame
        if (xfer) begin
            sample_d = xfer_frame;
            last_d   = {seq_q, xfer_last};
            valid_d  = 1'b1;
            seq_d    = xfer_last ? '0 : seq_q + SEQ_W'(1);
        end

        rdy_d = (state_d == ST_COLLECT);
    end

endmodule
